// File: rtl/mme_pkg.sv
// Shared types and defaults for the matrix-multiply engine controller.
package mme_pkg;

  // Default systolic array dimension (rows drained per command).
  localparam int unsigned MME_SIZE_DEFAULT = 4;

  // Inner-dimension width carried by a command.
  typedef logic [7:0] width_t;

  // Controller sequence: clear accumulators, launch providers, wait for
  // both providers, flush the array skew, drain result rows, report done.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/mme_ctrl_wdog.sv
// Watchdog counter for the provider wait phase of mme_ctrl.
// load restarts the count, each tick advances it, and expired flags the
// tick that completes TIMEOUT counted cycles.
module mme_ctrl_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count ticks since the last load; hold once the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (tick && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = tick && (cnt_q == LIMIT);

endmodule

// File: rtl/mme_ctrl.sv
// Sequencer for a SIZE x SIZE systolic matrix-multiply engine.
// Accepts a command, clears the accumulators, starts the A/B data
// providers, waits for both to finish, flushes the array skew, then drains
// SIZE result rows over a valid/ready handshake.
// Optional build macro MME_CTRL_TIMEOUT_EN adds a watchdog on the provider
// wait; on expiry err_o is set and the command is abandoned.
module mme_ctrl
  import mme_pkg::*;
#(
  parameter int unsigned SIZE    = MME_SIZE_DEFAULT,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [7:0]              cmd_width_i,
  output logic                    dp_start_o,
  output logic [7:0]              dp_width_o,
  input  logic                    dpa_done_i,
  input  logic                    dpb_done_i,
  output logic                    acc_clear_o,
  output logic                    acc_en_o,
  output logic [$clog2(SIZE)-1:0] rd_row_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned ROW_W = $clog2(SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);

  state_t           state_q;
  state_t           state_d;
  width_t           width_q;
  logic             sticky_a_q;
  logic             sticky_b_q;
  logic [ROW_W-1:0] flush_cnt_q;
  logic [ROW_W-1:0] rd_row_q;
  logic             accept;
  logic             both_done;
  logic             wdog_expired;

  assign accept    = cmd_valid_i && (state_q == S_IDLE);
  // A done seen this cycle counts as well as one captured earlier, so the
  // FSM leaves WAIT on the edge right after the last provider finishes.
  assign both_done = (sticky_a_q || dpa_done_i) && (sticky_b_q || dpb_done_i);

`ifdef MME_CTRL_TIMEOUT_EN
  logic err_q;

  mme_ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == S_LAUNCH),
    .tick    (state_q == S_WAIT),
    .expired (wdog_expired)
  );

  // Sticky timeout flag: set when a wait is abandoned, cleared by the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state_q == S_WAIT) && !both_done && wdog_expired) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  // TIMEOUT has no consumer without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wdog_expired   = 1'b0;
  assign err_o          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_valid_i) state_d = (cmd_width_i == 8'd0) ? S_DONE : S_CLEAR;
      S_CLEAR:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (both_done) begin
          state_d = S_FLUSH;
        end else if (wdog_expired) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH:  if (flush_cnt_q == LAST_ROW) state_d = S_DRAIN;
      S_DRAIN:  if (out_ready_i && (rd_row_q == LAST_ROW)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command width latch, provider done capture, flush and row counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_q     <= '0;
      sticky_a_q  <= 1'b0;
      sticky_b_q  <= 1'b0;
      flush_cnt_q <= '0;
      rd_row_q    <= '0;
    end else begin
      if (accept) begin
        width_q <= cmd_width_i;
      end

      if (state_q == S_LAUNCH) begin
        sticky_a_q <= 1'b0;
        sticky_b_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        sticky_a_q <= sticky_a_q || dpa_done_i;
        sticky_b_q <= sticky_b_q || dpb_done_i;
      end

      if (state_q == S_FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end else begin
        flush_cnt_q <= '0;
      end

      if (state_q == S_DRAIN) begin
        if (out_ready_i) begin
          rd_row_q <= (rd_row_q == LAST_ROW) ? '0 : rd_row_q + 1'b1;
        end
      end else begin
        rd_row_q <= '0;
      end
    end
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready_o = 1'b0;
    dp_start_o  = 1'b0;
    acc_clear_o = 1'b0;
    acc_en_o    = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   cmd_ready_o = 1'b1;
      S_CLEAR:  acc_clear_o = 1'b1;
      S_LAUNCH: begin
        dp_start_o = 1'b1;
        acc_en_o   = 1'b1;
      end
      S_WAIT:   acc_en_o    = 1'b1;
      S_FLUSH:  acc_en_o    = 1'b1;
      S_DRAIN:  out_valid_o = 1'b1;
      S_DONE:   done_o      = 1'b1;
      default:  cmd_ready_o = 1'b0;
    endcase
  end

  assign dp_width_o = width_q;
  assign rd_row_o   = rd_row_q;

endmodule

// File: doc/mme_ctrl.md
MME_CTRL -- requirements
Module: mme_ctrl

Interface
REQ-001 Parameter SIZE, default 4: systolic array dimension and number of result rows drained.
REQ-002 Parameter TIMEOUT, default 1024: watchdog limit in cycles; used only when MME_CTRL_TIMEOUT_EN is defined.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-007 cmd_width_i  input  8  matrix width (inner dimension) for the command.
REQ-008 dp_start_o  output  1  one-cycle start pulse to both data providers.
REQ-009 dp_width_o  output  8  latched width driven to both data providers.
REQ-010 dpa_done_i, dpb_done_i  input  1 each  done levels from the A-side and B-side data providers (high when idle).
REQ-011 acc_clear_o  output  1  clears array accumulators.
REQ-012 acc_en_o  output  1  array accumulate enable.
REQ-013 rd_row_o  output  $clog2(SIZE)  result row being drained.
REQ-014 out_valid_o  output  1  drain handshake: result row valid.
REQ-015 out_ready_i  input  1  drain handshake: consumer ready for the row.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle completion pulse.
REQ-018 err_o  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, LAUNCH, WAIT, FLUSH, DRAIN, DONE.
REQ-020 cmd_ready_o SHALL be high only in IDLE; on accept, the block SHALL latch cmd_width_i into dp_width_o and go to CLEAR, or to DONE if the width is 0.
REQ-021 In CLEAR, acc_clear_o SHALL be high for exactly 1 cycle, then the FSM SHALL go to LAUNCH.
REQ-022 In LAUNCH, dp_start_o and acc_en_o SHALL be high for exactly 1 cycle, then the FSM SHALL go to WAIT.
REQ-023 In WAIT, acc_en_o SHALL stay high.
REQ-024 In WAIT, each done input SHALL be captured in its own sticky bit, cleared on LAUNCH.
REQ-025 The FSM SHALL leave WAIT for FLUSH in the cycle after both sticky bits are set, including when both provider dones arrive in the same cycle.
REQ-026 FLUSH SHALL hold acc_en_o high for exactly SIZE cycles (skew drain), then go to DRAIN with rd_row_o=0.
REQ-027 In DRAIN, out_valid_o SHALL be high.
REQ-028 In DRAIN, rd_row_o SHALL advance only on out_valid_o&&out_ready_i; rd_row_o and out_valid_o SHALL stay stable while out_ready_i is low.
REQ-029 The handshake on row SIZE-1 SHALL move the FSM to DONE.
REQ-030 DONE SHALL assert done_o for 1 cycle, then return to IDLE.
REQ-031 cmd_valid_i SHALL be ignored outside IDLE; provider done inputs SHALL be ignored outside WAIT.

Reset
REQ-032 With rst_n low at a clock edge, the block SHALL enter IDLE: cmd_ready_o=1 after reset, dp_width_o=0, rd_row_o=0, sticky bits=0, err_o=0, and all other outputs 0.
REQ-033 Reset in any state SHALL abort the operation with no done_o pulse.

Configuration
REQ-034 With MME_CTRL_TIMEOUT_EN defined, a counter SHALL clear on LAUNCH and increment each WAIT cycle.
REQ-035 With MME_CTRL_TIMEOUT_EN defined, reaching TIMEOUT SHALL set err_o, return to IDLE without done_o, and clear err_o on the next command accept.
REQ-036 Without MME_CTRL_TIMEOUT_EN, the counter SHALL be absent and err_o SHALL be tied to 0.

Structure
REQ-037 Package mme_pkg SHALL hold the FSM state enum typedef, the SIZE default and the 8-bit width typedef.
REQ-038 The watchdog SHALL be sub-module mme_ctrl_wdog (load, tick, expired), instantiated only under MME_CTRL_TIMEOUT_EN.

Verification
REQ-039 Width 8, both dones rise 11 cycles after dp_start_o, out_ready_i=1 -> acc_clear_o 1 cycle after accept, dp_start_o 2 cycles after accept, acc_en_o high through FLUSH (4 cycles), rows 0,1,2,3 on consecutive cycles, one done_o pulse.
REQ-040 Width 0 -> no acc_clear_o, no dp_start_o, no out_valid_o; done_o 1 cycle after accept.
REQ-041 dpa_done_i rises 3 cycles before dpb_done_i -> FSM holds WAIT until dpb_done_i rises, then enters FLUSH the next cycle.
REQ-042 out_ready_i low for 5 cycles at row 2 -> rd_row_o=2 and out_valid_o=1 held for those 5 cycles, no skipped or repeated rows.
REQ-043 rst_n low for 1 cycle during FLUSH -> IDLE next cycle, cmd_ready_o=1, no done_o; a new width-4 command then completes normally.
REQ-044 MME_CTRL_TIMEOUT_EN defined, TIMEOUT=16, dones held low -> err_o=1 after 16 WAIT cycles, no done_o, err_o cleared on the next accept.
